zeroriscy_ss_arbiter: RTL

Two-master arbiter for the system (AXI bridge) slave port of the zero-riscy platform. It shares the single req/gnt/rvalid port feeding core2axi between master 0 (the core data port, routed through the crossbar) and master 1 (the loader/DMA master). It provides round-robin arbitration with request locking until grant. An ID FIFO records which master owns each outstanding transaction and routes responses back in order.

---
 rtl/zeroriscy_ss_pkg.sv | 23 ++
 rtl/zeroriscy_id_fifo.sv | 54 +++++
 rtl/zeroriscy_ss_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/zeroriscy_ss_pkg.sv
// Shared types and constants for the zero-riscy system-slave arbiter.
// The master ID and the request-attribute bundle are used by the arbiter and its ID FIFO.
package zeroriscy_ss_pkg;

  localparam int NUM_MASTERS = 2;

  typedef logic mid_t;

  localparam mid_t M_CORE = 1'b0;
  localparam mid_t M_DMA  = 1'b1;

  localparam int SS_ADDR_W = 32;
  localparam int SS_DATA_W = 32;
  localparam int SS_BE_W   = SS_DATA_W / 8;

  typedef struct packed {
    logic                 we;
    logic [SS_BE_W-1:0]   be;
    logic [SS_ADDR_W-1:0] addr;
    logic [SS_DATA_W-1:0] wdata;
  } ss_attr_t;

endpackage

// File: rtl/zeroriscy_id_fifo.sv
// In-order FIFO of master IDs for outstanding slave transactions.
// Pushes are ignored when full and pops are ignored when empty.
module zeroriscy_id_fifo
  import zeroriscy_ss_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  mid_t          wdata_i,
  input  logic          pop_i,
  output mid_t          rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  mid_t          mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= M_CORE;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (pop_ok) rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/zeroriscy_ss_arbiter.sv
// Round-robin two-master arbiter for the core2axi slave port, with lock-until-grant
// and an ID FIFO steering in-order responses back to the issuing master.
module zeroriscy_ss_arbiter
  import zeroriscy_ss_pkg::*;
#(
  parameter int ADDR_W = SS_ADDR_W,
  parameter int DATA_W = SS_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_MASTERS-1:0]                   m_req,
  input  logic [NUM_MASTERS-1:0]                   m_we,
  input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0]     m_be,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]       m_addr,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]       m_wdata,
  output logic [NUM_MASTERS-1:0]                   m_gnt,
  output logic [NUM_MASTERS-1:0]                   m_rvalid,
  output logic [DATA_W-1:0]                        m_rdata,
  output logic [NUM_MASTERS-1:0]                   m_err,
  output logic                                     s_req,
  output logic                                     s_we,
  output logic [DATA_W/8-1:0]                      s_be,
  output logic [ADDR_W-1:0]                        s_addr,
  output logic [DATA_W-1:0]                        s_wdata,
  input  logic                                     s_gnt,
  input  logic                                     s_rvalid,
  input  logic [DATA_W-1:0]                        s_rdata,
  input  logic                                     s_err,
  output logic                                     proto_err
);

  localparam int CW = $clog2(DEPTH + 1);

  ss_attr_t      attr [NUM_MASTERS];
  ss_attr_t      sel_attr;
  mid_t          sel, head;
  mid_t          rr_q, rr_d, lock_id_q, lock_id_d;
  logic          lock_q, lock_d, proto_q, proto_d;
  logic          issue, hs, resp_ok;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
    assign attr[i] = '{we: m_we[i], be: m_be[i], addr: m_addr[i], wdata: m_wdata[i]};
    assign m_gnt[i]    = hs & (sel == mid_t'(i));
    assign m_rvalid[i] = resp_ok & (head == mid_t'(i));
    assign m_err[i]    = resp_ok & s_err & (head == mid_t'(i));
  end

  // A held lock wins over round-robin so a stalled request is never preempted.
  always_comb begin
    sel = M_CORE;
    if (lock_q)              sel = lock_id_q;
    else if (&m_req)         sel = rr_q;
    else if (m_req[M_DMA])   sel = M_DMA;
  end

  assign sel_attr = attr[sel];

  // Outputs are gated by rst_n so they read zero while reset is held.
  assign issue   = rst_n & (|m_req) & ~fifo_full;
  assign hs      = issue & s_gnt;
  assign resp_ok = rst_n & s_rvalid & (fifo_cnt != '0);

  assign s_req     = issue;
  assign s_we      = issue & sel_attr.we;
  assign s_be      = issue ? sel_attr.be    : '0;
  assign s_addr    = issue ? sel_attr.addr  : '0;
  assign s_wdata   = issue ? sel_attr.wdata : '0;
  assign m_rdata   = rst_n ? s_rdata : '0;
  assign proto_err = proto_q;

  always_comb begin
    rr_d      = hs ? ~sel : rr_q;
    lock_d    = issue & ~s_gnt;
    lock_id_d = lock_d ? sel : lock_id_q;
    proto_d   = proto_q | (s_rvalid & fifo_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= M_CORE;
      lock_q    <= 1'b0;
      lock_id_q <= M_CORE;
      proto_q   <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      proto_q   <= proto_d;
    end
  end

  zeroriscy_id_fifo #(.DEPTH(DEPTH)) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (hs),
    .wdata_i (sel),
    .pop_i   (resp_ok),
    .rdata_o (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
